mux8_scan_sequencer: RTL and testbench
======================================

// Module: mux8_scan_sequencer
// PURPOSE
//   Upstream/downstream companion of the 8:1 mux: drives the mux selects S2:S0 through
//   channels 0..7, waits a settle time per channel and samples the mux output Y.
//   Assembles one 8-bit word per scan (bit k = input Ik) and flags it with a 1-cycle valid.
//   Supports single-shot or continuous scanning.
// PARAMETERS
//   SETTLE_CYCLES  1  cycles select is held before sampling Y (legal 1..255; 0 treated as 1)
//   CONTINUOUS     0  0: one scan per start; 1: rescan back-to-back until stop
// PORTS
//   clk       in   1  clock, all state changes on rising edge
//   rst       in   1  synchronous, active-high reset
//   start     in   1  request a scan; sampled only in IDLE
//   stop      in   1  end continuous scanning after the current scan completes
//   mux_y     in   1  Y output of the 8:1 mux
//   S0,S1,S2  out  1  mux select lines, {S2,S1,S0} = current channel index
//   data_out  out  8  last completed scan word, bit k = sampled Ik
//   valid     out  1  1-cycle pulse: data_out updated this cycle
//   busy      out  1  high from first SETTLE cycle through final SAMPLE cycle
// BEHAVIOUR
//   Reset (rst=1 at edge, any state, incl. mid-scan): state=IDLE, sel=0, settle cnt=0,
//     shadow=0, data_out=8'h00, valid=0, busy=0, stop_req=0. Partial scan discarded.
//   States: IDLE, SETTLE, SAMPLE, DONE (2-bit encoded).
//   IDLE: sel=0. start=1 -> SETTLE, cnt=SETTLE_CYCLES-1, busy=1.
//   SETTLE: sel held; cnt==0 -> SAMPLE, else cnt--. Lasts exactly SETTLE_CYCLES cycles.
//   SAMPLE (1 cycle): shadow[sel] <= mux_y at the closing edge.
//     sel<7 -> sel++, cnt reloaded, -> SETTLE.
//     sel==7 -> data_out <= {mux_y, shadow[6:0]}, valid<=1, busy<=0, sel<=0 -> DONE.
//   DONE (1 cycle, valid=1): CONTINUOUS=1 and stop_req=0 -> SETTLE (new scan, busy=1,
//     no DONE->IDLE gap); else -> IDLE, stop_req cleared.
//   Select {S2,S1,S0} changes only on SAMPLE->SETTLE or SAMPLE->DONE edges; stable
//     throughout each channel's SETTLE+SAMPLE window. Registered outputs, no glitches.
//   Timing: per channel N+1 cycles (N=SETTLE_CYCLES). start sampled at edge of cycle 0
//     -> channel k sampled in cycle (k+1)(N+1); valid high in cycle 8(N+1)+1.
//     Continuous: one valid every 8(N+1)+1 cycles.
//   start while busy or in DONE: ignored (not queued).
//   stop: sampled every cycle outside IDLE, sets sticky stop_req; current scan always
//     completes and emits valid. stop in IDLE: no effect. stop ignored when CONTINUOUS=0.
//   start and stop same cycle in IDLE: scan starts; CONTINUOUS=1 -> single scan only.
//   data_out holds last word until next valid; never shows a partial scan.
//   sel wraps 7->0 only via DONE; never exceeds 7.
// TESTING
//   1. N=1, CONTINUOUS=0, mux model with I=8'hA5, start pulse cycle 0 -> {S2,S1,S0}
//      steps 0..7 every 2 cycles, valid only in cycle 17, data_out=8'hA5, busy low after.
//   2. N=3, I=8'h3C -> each select held 4 cycles, valid in cycle 33, data_out=8'h3C;
//      change I to 8'hFF inside a SETTLE window of ch2 only -> bit2 reflects the value at sample.
//   3. start re-pulsed every cycle during scan -> exactly one valid, no restart, sel
//      sequence unchanged.
//   4. CONTINUOUS=1, N=1, I=8'h01 then 8'h80 -> valid every 17 cycles with 8'h01 then 8'h80;
//      stop pulse mid-scan -> that scan completes, valid, then IDLE, busy=0.
//   5. rst asserted at sel=4 in SETTLE -> next cycle all outputs zero, state IDLE;
//      new start -> full scan from ch0, prior partial bits absent from data_out.
//   6. SETTLE_CYCLES=0 -> identical timing to N=1 (valid in cycle 17).

Source files
------------

// File: rtl/mux8_scan_sequencer.sv
// rtl/mux8_scan_sequencer.sv - steps an 8:1 mux through channels 0..7 and assembles one sampled word per scan
// Single-shot or continuous scanning; SETTLE_CYCLES of 0 behaves as 1.
module mux8_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mux_y,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy
);

  localparam int         N_EFF    = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0] CNT_LOAD = 8'(N_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       stop_req_q, stop_req_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    stop_req_d = stop_req_q;

    // stop is sticky once a scan is in flight; honoured at the next DONE
    if (CONTINUOUS && stop && state_q != IDLE) stop_req_d = 1'b1;

    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d    = SETTLE;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          stop_req_d = CONTINUOUS && stop;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SAMPLE: begin
        shadow_d[sel_q] = mux_y;
        if (sel_q != 3'd7) begin
          sel_d   = sel_q + 3'd1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          data_d  = {mux_y, shadow_q[6:0]};
          valid_d = 1'b1;
          busy_d  = 1'b0;
          sel_d   = 3'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (CONTINUOUS && !stop_req_q) begin
          state_d = SETTLE;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d    = IDLE;
          stop_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 3'd0;
      cnt_q      <= 8'd0;
      shadow_q   <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      stop_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      stop_req_q <= stop_req_d;
    end
  end

  assign S0       = sel_q[0];
  assign S1       = sel_q[1];
  assign S2       = sel_q[2];
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// tb/tb_mux8_scan_sequencer.sv - bench for mux8_scan_sequencer across four parameter sets
module tb_mux8_scan_sequencer;

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] start;
  logic [3:0] stop;
  logic [7:0] iv [4];
  wire  [3:0] s0, s1, s2, valid_o, busy_o, mux_y;
  wire  [7:0] dout [4];
  logic [2:0] sel_o [4];

  int tests = 0;
  int fails = 0;
  logic [7:0] sbq [$];
  int nv [4] = '{1, 3, 1, 1};

  typedef struct {
    int         d;
    logic [7:0] word;
    logic [7:0] exp;
    bit         restart;
    int         g0;
    int         g1;
    logic [7:0] gword;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  mux8_scan_sequencer #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b0)) u_n1 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .mux_y(mux_y[0]),
    .S0(s0[0]), .S1(s1[0]), .S2(s2[0]), .data_out(dout[0]), .valid(valid_o[0]), .busy(busy_o[0]));
  mux8_scan_sequencer #(.SETTLE_CYCLES(3), .CONTINUOUS(1'b0)) u_n3 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .mux_y(mux_y[1]),
    .S0(s0[1]), .S1(s1[1]), .S2(s2[1]), .data_out(dout[1]), .valid(valid_o[1]), .busy(busy_o[1]));
  mux8_scan_sequencer #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .rst(rst[2]), .start(start[2]), .stop(stop[2]), .mux_y(mux_y[2]),
    .S0(s0[2]), .S1(s1[2]), .S2(s2[2]), .data_out(dout[2]), .valid(valid_o[2]), .busy(busy_o[2]));
  mux8_scan_sequencer #(.SETTLE_CYCLES(0), .CONTINUOUS(1'b0)) u_n0 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .stop(stop[3]), .mux_y(mux_y[3]),
    .S0(s0[3]), .S1(s1[3]), .S2(s2[3]), .data_out(dout[3]), .valid(valid_o[3]), .busy(busy_o[3]));

  // behavioural 8:1 mux in front of each sequencer
  for (genvar g = 0; g < 4; g++) begin : g_mux
    assign sel_o[g] = {s2[g], s1[g], s0[g]};
    assign mux_y[g] = iv[g][sel_o[g]];
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_valid(input int d);
    if (sbq.size() == 0) begin
      cmp($sformatf("unexpected valid d%0d", d), 32'd1, 32'd0);
    end else begin
      logic [7:0] e;
      e = sbq.pop_front();
      cmp($sformatf("data_out d%0d", d), {24'd0, dout[d]}, {24'd0, e});
    end
  endtask

  // start at cycle 0, then check select/busy/valid every cycle against the timing model
  task automatic run_scan(input vec_t v);
    int d, n, last, bad_c;
    logic [4:0] bad_act, bad_exp, act, exp;
    d = v.d; n = nv[d]; last = 8 * (n + 1) + 1; bad_c = -1;
    bad_act = '0; bad_exp = '0;
    @(negedge clk);
    iv[d] = v.word; start[d] = 1'b1;
    sbq.push_back(v.exp);
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      exp = {(c < last) ? 3'((c - 1) / (n + 1)) : 3'd0, c < last, c == last};
      act = {sel_o[d], busy_o[d], valid_o[d]};
      if (act !== exp && bad_c < 0) begin
        bad_c = c; bad_act = act; bad_exp = exp;
      end
      if (valid_o[d]) check_valid(d);
      start[d] = v.restart && (c < last);
      iv[d] = (c >= v.g0 && c < v.g1) ? v.gword : v.word;
    end
    cmp($sformatf("trace d%0d first bad cycle %0d {sel,busy,valid}", d, bad_c),
        {27'd0, bad_act}, {27'd0, bad_exp});
    cmp($sformatf("scoreboard drained d%0d", d), sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_valid(input int d, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start[d] = 1'b0; stop[d] = 1'b0;
      if (valid_o[d]) begin
        check_valid(d);
        cyc = c;
        break;
      end
    end
    if (cyc < 0) cmp($sformatf("valid timeout d%0d", d), 32'd0, 32'd1);
  endtask

  task automatic quiet(input int d, input int ncyc);
    int seen;
    seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (valid_o[d] || busy_o[d]) seen++;
    end
    cmp($sformatf("idle after scan d%0d", d), seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0, 0, 0, 8'h00};
    tbl[1] = '{1, 8'h3C, 8'h3C, 1'b0, 0, 0, 8'h00};
    tbl[2] = '{1, 8'h3C, 8'h3C, 1'b0, 9, 12, 8'hFF};
    tbl[3] = '{1, 8'h3C, 8'h38, 1'b0, 11, 13, 8'h38};
    tbl[4] = '{1, 8'h3C, 8'h3C, 1'b0, 9, 12, 8'h38};
    tbl[5] = '{0, 8'h5A, 8'h5A, 1'b1, 0, 0, 8'h00};
    tbl[6] = '{3, 8'hC3, 8'hC3, 1'b0, 0, 0, 8'h00};
    tbl[7] = '{1, 8'h96, 8'h96, 1'b1, 0, 0, 8'h00};

    rst = 4'hF; start = '0; stop = '0;
    for (int i = 0; i < 4; i++) iv[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      cmp($sformatf("reset outputs d%0d", i),
          {19'd0, sel_o[i], dout[i], busy_o[i], valid_o[i]}, 32'd0);
    rst = 4'h0;

    for (int i = 0; i < 8; i++) run_scan(tbl[i]);

    // continuous: back-to-back words, then stop mid-scan
    iv[2] = 8'h01; start[2] = 1'b1; sbq.push_back(8'h01);
    wait_valid(2, 40, cyc);
    cmp("cont first valid cycle", cyc, 17);
    iv[2] = 8'h80; sbq.push_back(8'h80);
    wait_valid(2, 40, cyc);
    cmp("cont second valid period", cyc, 17);
    sbq.push_back(8'h80);
    repeat (8) @(negedge clk);
    stop[2] = 1'b1;
    wait_valid(2, 40, cyc);
    cmp("cont stopped scan completes", cyc, 9);
    quiet(2, 20);

    // start and stop together: single scan only
    iv[2] = 8'h5A; start[2] = 1'b1; stop[2] = 1'b1; sbq.push_back(8'h5A);
    wait_valid(2, 40, cyc);
    cmp("start+stop valid cycle", cyc, 17);
    quiet(2, 20);

    // reset mid-scan at ch4 SETTLE
    iv[0] = 8'hFF; start[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    cmp("pre-reset sel/busy", {28'd0, sel_o[0], busy_o[0]}, {28'd0, 3'd4, 1'b1});
    rst[0] = 1'b1;
    @(negedge clk);
    cmp("mid-scan reset outputs", {19'd0, sel_o[0], dout[0], busy_o[0], valid_o[0]}, 32'd0);
    rst[0] = 1'b0;
    run_scan('{0, 8'hF0, 8'hF0, 1'b0, 0, 0, 8'h00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
